// File: rtl/param_fifo.sv
// -----------------------------------------------------------------------------
// param_fifo
//   Synchronous single-clock FIFO with runtime almost-full/almost-empty
//   thresholds, sticky overflow/underflow flags and a selectable read mode
//   (registered read or first-word-fall-through).
//
// Parameters
//   DATA_W : data width in bits (>=1)
//   DEPTH  : number of entries (>=2, any value, not only powers of two)
//   FWFT   : 0 = registered read, 1 = first-word-fall-through
//   CW     : width of count/threshold signals, $clog2(DEPTH+1)
//
// Ports
//   clk         : single clock, all state updates on its rising edge
//   rstn        : asynchronous active-low reset
//   i_wren      : write request
//   i_wrdata    : write data
//   i_rden      : read request
//   o_rddata    : read data
//   o_rdvalid   : o_rddata qualifier
//   i_upp_th    : almost-full threshold  (o_alm_full  = count >= i_upp_th)
//   i_low_th    : almost-empty threshold (o_alm_empty = count <= i_low_th)
//   o_full      : count == DEPTH
//   o_alm_full  : count >= i_upp_th
//   o_empty     : count == 0
//   o_alm_empty : count <= i_low_th
//   o_count     : current occupancy
//   o_ovf       : sticky, write attempted while full with no read
//   o_udf       : sticky, read attempted while empty
//   i_clr_err   : clears o_ovf/o_udf (a same-cycle set wins)
// -----------------------------------------------------------------------------
module param_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter bit FWFT   = 1'b0,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  input  logic [CW-1:0]     i_upp_th,
  input  logic [CW-1:0]     i_low_th,
  output logic              o_full,
  output logic              o_alm_full,
  output logic              o_empty,
  output logic              o_alm_empty,
  output logic [CW-1:0]     o_count,
  output logic              o_ovf,
  output logic              o_udf,
  input  logic              i_clr_err
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic full;
  logic empty;
  logic rd_ok;
  logic wr_ok;
  logic ovf_set;
  logic udf_set;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO still accepts a write when a read frees a slot in the same
  // cycle; an empty FIFO never bypasses write data to the read side.
  assign rd_ok   = i_rden && !empty;
  assign wr_ok   = i_wren && (!full || rd_ok);
  assign ovf_set = i_wren && !wr_ok;
  assign udf_set = i_rden && empty;

  assign o_full      = full;
  assign o_empty     = empty;
  assign o_count     = count;
  assign o_alm_full  = (count >= i_upp_th);
  assign o_alm_empty = (count <= i_low_th);

  // NOTE: storage has no reset; the pointers and count define which entries
  // are live, so clearing the array would only cost area and timing.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= i_wrdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_ovf  <= 1'b0;
      o_udf  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
      if (rd_ok) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Set has priority over clear so an error in the clearing cycle is kept.
      if (ovf_set)        o_ovf <= 1'b1;
      else if (i_clr_err) o_ovf <= 1'b0;
      if (udf_set)        o_udf <= 1'b1;
      else if (i_clr_err) o_udf <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head entry is visible as soon as it exists; a read just advances it.
      assign o_rddata  = mem[rd_ptr];
      assign o_rdvalid = !empty;
    end else begin : g_reg
      logic [DATA_W-1:0] rddata_q;
      logic              rdvalid_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rddata_q  <= '0;
          rdvalid_q <= 1'b0;
        end else begin
          rdvalid_q <= rd_ok;
          if (rd_ok) rddata_q <= mem[rd_ptr];
        end
      end

      assign o_rddata  = rddata_q;
      assign o_rdvalid = rdvalid_q;
    end
  endgenerate

endmodule
